jtag_dr_word_bridge: RTL

- Sits directly downstream of the BSCANE2 wrapper and runs in the TCK domain (clk = wrapper tck).
- Deserialises DR shift traffic into 32-bit words, LSB first, and buffers them in a small first-word-fall-through (FWFT) FIFO for the JTAG-to-AXI command decoder.
- Serialises return words from the decoder onto tdo.
- On capture_dr, loads a status word so the host can read FIFO state before each scan.

---
 rtl/jtag_dr_word_bridge.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/jtag_dr_word_bridge.sv
// DR shift-path bridge in the TCK domain: 32-bit LSB-first words into an RX FWFT FIFO, return words onto tdo.
// Optional JTAG_RX_WORD_COUNT_EN adds rx_word_count and reports its low 12 bits in status [23:12].
module jtag_dr_word_bridge #(
  parameter int unsigned FIFO_AW = 3,
  parameter logic [7:0]  ID_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jtag_reset,
  input  logic        tdi,
  input  logic        capture_dr,
  input  logic        shift_dr,
  input  logic        update_dr,
  output logic        tdo,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
`ifdef JTAG_RX_WORD_COUNT_EN
  output logic [15:0] rx_word_count,
`endif
  output logic        in_ready
);

  localparam int unsigned        DEPTH    = 1 << FIFO_AW;
  localparam logic [8:0]         DEPTH9   = 9'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_ZERO = (FIFO_AW + 1)'(0);

  // Only rx_sr[31:1] is ever observed, so bit 0 is not stored.
  logic [30:0]        r_rx_hi;
  logic [31:0]        r_tx_sr;
  logic [4:0]         r_bitcnt;
  logic               r_rx_ovf;
  logic               r_tx_unf;
  logic               r_partial;
  logic [31:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;

  logic        w_rst;
  logic        w_shift;
  logic        w_upd;
  logic        w_word_end;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_unf_set;
  logic        w_part_set;
  logic [31:0] w_rx_word;
  logic [8:0]  w_free9;
  logic [7:0]  w_free;
  logic [11:0] w_status_mid;
  logic [31:0] w_status;

  assign w_rst      = ~rstn | jtag_reset;
  assign w_shift    = shift_dr & ~capture_dr;
  assign w_upd      = update_dr & ~capture_dr & ~shift_dr;
  assign w_word_end = w_shift & (r_bitcnt == 5'd31);
  assign w_rx_word  = {tdi, r_rx_hi};

  assign out_valid  = (r_count != CNT_ZERO);
  assign out_data   = out_valid ? r_mem[r_rptr] : 32'd0;
  assign w_full     = r_count[FIFO_AW];
  assign w_pop      = out_valid & out_ready;
  assign w_push     = w_word_end & (~w_full | w_pop);
  assign w_ovf_set  = w_word_end & w_full & ~w_pop;
  assign w_unf_set  = w_word_end & ~in_valid;
  assign w_part_set = w_upd & (r_bitcnt != 5'd0);

  assign tdo        = r_tx_sr[0];
  assign in_ready   = ~w_rst & w_word_end & in_valid;

`ifdef JTAG_RX_WORD_COUNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_word_cnt <= 16'd0;
    end else if (w_push) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign rx_word_count = r_word_cnt;
  assign w_status_mid  = r_word_cnt[11:0];
`else
  assign w_status_mid  = 12'd0;
`endif

  always_comb begin
    w_free9 = DEPTH9 - 9'(r_count);
    if (w_free9 > 9'd255) begin
      w_free = 8'hFF;
    end else begin
      w_free = w_free9[7:0];
    end
    w_status = {ID_BYTE, w_status_mid, r_partial, r_tx_unf, r_rx_ovf, in_valid, w_free};
  end

  // Shift registers, bit counter and sticky flags; capture outranks shift, shift outranks update.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_rx_hi   <= 31'd0;
      r_tx_sr   <= 32'd0;
      r_bitcnt  <= 5'd0;
      r_rx_ovf  <= 1'b0;
      r_tx_unf  <= 1'b0;
      r_partial <= 1'b0;
    end else begin
      if (capture_dr) begin
        r_tx_sr  <= w_status;
        r_bitcnt <= 5'd0;
      end else if (w_shift) begin
        r_rx_hi  <= w_rx_word[31:1];
        r_bitcnt <= r_bitcnt + 5'd1;
        if (r_bitcnt == 5'd31) begin
          r_tx_sr <= in_valid ? in_data : 32'd0;
        end else begin
          r_tx_sr <= {1'b0, r_tx_sr[31:1]};
        end
      end else if (w_part_set) begin
        r_bitcnt <= 5'd0;
      end
      r_rx_ovf  <= (r_rx_ovf  & ~capture_dr) | w_ovf_set;
      r_tx_unf  <= (r_tx_unf  & ~capture_dr) | w_unf_set;
      r_partial <= (r_partial & ~capture_dr) | w_part_set;
    end
  end

  // FIFO storage is flushed through the pointers, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_push && !w_rst) begin
      r_mem[r_wptr] <= w_rx_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
